// File: rtl/pe_link_pkg.sv
// Shared definitions for both ends of the 130-bit inter-PE link: flit layout, FSM states, flit packer.
package pe_link_pkg;

  localparam int LINK_WIDTH     = 130;
  localparam int DATA_WIDTH     = 32;
  localparam int VALID_BIT      = 129;
  localparam int LAST_BIT       = 128;
  localparam int CNT_LSB        = 96;
  localparam int WORDS_PER_FLIT = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SEND
  } link_state_t;

  // Bits between the count field and LAST stay zero.
  function automatic logic [LINK_WIDTH-1:0] pack_flit(
    input logic                                 last,
    input logic [1:0]                           cnt_m1,
    input logic [WORDS_PER_FLIT*DATA_WIDTH-1:0] lanes
  );
    logic [LINK_WIDTH-1:0] f;
    f                  = '0;
    f[VALID_BIT]       = 1'b1;
    f[LAST_BIT]        = last;
    f[CNT_LSB +: 2]    = cnt_m1;
    f[CNT_LSB-1:0]     = lanes;
    return f;
  endfunction

endpackage

// File: rtl/pe_link_credit_ctr.sv
// Credit counter for the link transmitter: starts full, one credit per flit sent, saturates at CREDITS.
// A return arriving while already full sets the sticky credit_err; a same-cycle send and return cancel out.
module pe_link_credit_ctr #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             consume,
  input  logic             credit_return,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             credit_err
);

  localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt <= MAX_CREDITS;
      credit_err <= 1'b0;
    end else if (consume && !credit_return) begin
      credit_cnt <= credit_cnt - ONE;
    end else if (credit_return && !consume) begin
      if (credit_cnt == MAX_CREDITS) begin
        credit_err <= 1'b1;
      end else begin
        credit_cnt <= credit_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/pe_link_tx.sv
// Link transmitter: packs 32-bit words into 3-lane flits; out_link valid 2 cycles after the completing word.
// Holds s_ready low while sending; stalls in SEND with the flit held until a credit is available.
module pe_link_tx #(
  parameter int LINK_WIDTH = 130,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  credit_return,
  output logic [LINK_WIDTH-1:0] out_link,
  output logic                  busy,
  output logic                  credit_err,
  output logic [CNT_WIDTH-1:0]  flit_count
);

  import pe_link_pkg::*;

  localparam int CREDIT_W = $clog2(CREDITS + 1);

  link_state_t state, state_nxt;

  logic [WORDS_PER_FLIT-1:0][DATA_WIDTH-1:0] lanes;
  logic [1:0]          lane_cnt;
  logic                in_pkt;
  logic                last_q;
  logic                accept;
  logic                complete;
  logic                send;
  logic                credit_avail;
  logic [CREDIT_W-1:0] credit_cnt;

  pe_link_credit_ctr #(
    .CREDITS (CREDITS),
    .CNT_W   (CREDIT_W)
  ) u_credit (
    .clk           (clk),
    .reset         (reset),
    .consume       (send),
    .credit_return (credit_return),
    .credit_cnt    (credit_cnt),
    .credit_err    (credit_err)
  );

  assign credit_avail = (credit_cnt != '0);
  assign busy         = (state != IDLE) || in_pkt;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    send      = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start || in_pkt) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          accept = 1'b1;
          if (lane_cnt == 2'(WORDS_PER_FLIT - 1) || s_last) begin
            complete  = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (credit_avail) begin
          send = 1'b1;
          // A packet stays open across flits even if ap_start has dropped.
          state_nxt = ((in_pkt && !last_q) || ap_start) ? FILL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lanes      <= '0;
      lane_cnt   <= '0;
      in_pkt     <= 1'b0;
      last_q     <= 1'b0;
      out_link   <= '0;
      flit_count <= '0;
    end else begin
      state    <= state_nxt;
      out_link <= '0;
      if (accept) begin
        lanes[lane_cnt] <= s_data;
        lane_cnt        <= lane_cnt + 2'd1;
        in_pkt          <= 1'b1;
        if (complete) begin
          last_q <= s_last;
        end
      end
      if (send) begin
        out_link   <= pack_flit(last_q, lane_cnt - 2'd1, lanes);
        flit_count <= flit_count + CNT_WIDTH'(1);
        lanes      <= '0;
        lane_cnt   <= '0;
        if (last_q) begin
          in_pkt <= 1'b0;
        end
      end
    end
  end

endmodule
